// File: rtl/simd_rf_sequencer_if.sv
// Sequencer bus: instruction issue handshake, register-file rs1/rs2 read ports and rd write port.
interface simd_rf_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic              instr_mode;
    logic [ADDR_W-1:0] instr_src1;
    logic [ADDR_W-1:0] instr_src2;
    logic [ADDR_W-1:0] instr_dst;

    logic [ADDR_W-1:0] rf_rs1;
    logic [ADDR_W-1:0] rf_rs2;
    logic              rf_rs1_rd_en;
    logic              rf_rs2_rd_en;
    logic [DATA_W-1:0] rf_rs1_data;
    logic [DATA_W-1:0] rf_rs2_data;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wr_data;
    logic              rf_rd_wr_en;

    logic              busy;
    logic              done;

    // Sequencer side.
    modport master (
        input  instr_valid, instr_op, instr_mode, instr_src1, instr_src2, instr_dst,
        input  rf_rs1_data, rf_rs2_data,
        output instr_ready,
        output rf_rs1, rf_rs2, rf_rs1_rd_en, rf_rs2_rd_en,
        output rf_rd, rf_wr_data, rf_rd_wr_en,
        output busy, done
    );

    // Issue stage plus register file side.
    modport slave (
        output instr_valid, instr_op, instr_mode, instr_src1, instr_src2, instr_dst,
        output rf_rs1_data, rf_rs2_data,
        input  instr_ready,
        input  rf_rs1, rf_rs2, rf_rs1_rd_en, rf_rs2_rd_en,
        input  rf_rd, rf_wr_data, rf_rd_wr_en,
        input  busy, done
    );
endinterface

// File: rtl/simd_rf_sequencer.sv
// Lane-wise SIMD ALU sequencer over a 16-bit register file (SIMD_SAT_EN: saturating ADD/SUB).
// Latency: accept -> READ -> EXEC -> WB, one instruction per 4 cycles; instr_ready low while busy.
module simd_rf_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    simd_rf_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [2:0]        op_q;
    logic              mode_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] alu_res;

    // One lane of up to 8 bits; narrow lanes arrive zero-extended and the caller keeps the low nibble.
    function automatic logic [7:0] lane_op(input logic [2:0] op, input logic narrow,
                                           input logic [7:0] a, input logic [7:0] b);
        logic [7:0] add_r;
        logic [7:0] sub_r;
`ifdef SIMD_SAT_EN
        logic [8:0] sum;
        logic [8:0] dif;
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} - {1'b0, b};
        add_r = (narrow ? sum[4] : sum[8]) ? 8'hFF : sum[7:0];
        sub_r = dif[8] ? 8'h00 : dif[7:0];
`else
        add_r = narrow ? {4'h0, a[3:0] + b[3:0]} : a + b;
        sub_r = narrow ? {4'h0, a[3:0] - b[3:0]} : a - b;
`endif
        case (op)
            3'b000:  lane_op = add_r;
            3'b001:  lane_op = sub_r;
            3'b010:  lane_op = a & b;
            3'b011:  lane_op = a | b;
            3'b100:  lane_op = a ^ b;
            3'b101:  lane_op = (a < b) ? a : b;
            3'b110:  lane_op = (a > b) ? a : b;
            default: lane_op = a;
        endcase
    endfunction

    always_comb begin
        alu_res = '0;
        if (mode_q) begin
            for (int l = 0; l < 2; l++) begin
                alu_res[l*8 +: 8] = lane_op(op_q, 1'b0, opa_q[l*8 +: 8], opb_q[l*8 +: 8]);
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                alu_res[l*4 +: 4] = 4'(lane_op(op_q, 1'b1, {4'h0, opa_q[l*4 +: 4]},
                                               {4'h0, opb_q[l*4 +: 4]}));
            end
        end
    end

    assign accept = bus.instr_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            mode_q   <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.instr_op;
                mode_q <= bus.instr_mode;
                src1_q <= bus.instr_src1;
                src2_q <= bus.instr_src2;
                dst_q  <= bus.instr_dst;
            end
            if (state == READ) begin
                opa_q <= bus.rf_rs1_data;
                opb_q <= bus.rf_rs2_data;
            end
            if (state == EXEC) begin
                result_q <= alu_res;
            end
        end
    end

    // Outputs decode from the state register alone, so a reset in WB kills the write at once.
    always_comb begin
        state_nxt        = state;
        bus.instr_ready  = 1'b0;
        bus.rf_rs1       = '0;
        bus.rf_rs2       = '0;
        bus.rf_rs1_rd_en = 1'b0;
        bus.rf_rs2_rd_en = 1'b0;
        bus.rf_rd        = '0;
        bus.rf_wr_data   = '0;
        bus.rf_rd_wr_en  = 1'b0;
        bus.done         = 1'b0;
        bus.busy         = (state != IDLE);
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                bus.rf_rs1       = src1_q;
                bus.rf_rs2       = src2_q;
                bus.rf_rs1_rd_en = 1'b1;
                bus.rf_rs2_rd_en = 1'b1;
                state_nxt        = EXEC;
            end
            EXEC: begin
                state_nxt = WB;
            end
            WB: begin
                bus.rf_rd       = dst_q;
                bus.rf_wr_data  = result_q;
                bus.rf_rd_wr_en = (dst_q != '0);
                bus.done        = 1'b1;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
